dds_rom_ctrl: RTL

//  Phase-accumulator sequencer that drives the 1024x16 sine ROM (sin_rom) as a DDS tone source.

---
 rtl/dds_rom_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dds_rom_ctrl.sv
// DDS tone sequencer: walks a phase accumulator, issues one sine-ROM read per clock while
// running, and realigns the returned ROM data with a valid strobe for downstream sample logic.
module dds_rom_ctrl #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 16,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               start,
    input  logic               stop,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int                 DRAIN_W    = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROM_LAT);
    localparam logic [LEN_W-1:0]   CNT_ONE    = LEN_W'(1);

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   ftw_q, ftw_d;
    logic [PHASE_W-1:0]   start_phase_q, start_phase_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]    dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic [ROM_LAT-1:0]   en_pipe_q, en_pipe_d;

    logic                 cfg_take;
    logic [PHASE_W-1:0]   eff_ftw;
    logic [PHASE_W-1:0]   eff_phase;
    logic                 burst_end;
    logic                 data_present;

    // A config offered in the same IDLE cycle as start is used by that start.
    assign cfg_take  = cfg_valid && cfg_ready_q;
    assign eff_ftw   = cfg_take ? cfg_ftw   : ftw_q;
    assign eff_phase = cfg_take ? cfg_phase : start_phase_q;

    // cnt_q counts reads already issued; the cycle showing the last read ends the burst.
    assign burst_end = stop || ((len_q != '0) && (cnt_q == len_q));

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        ftw_d         = ftw_q;
        start_phase_d = start_phase_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        drain_cnt_d   = drain_cnt_q;
        rom_en_d      = 1'b0;
        rom_addr_d    = rom_addr_q;
        done_d        = 1'b0;

        if (cfg_take) begin
            ftw_d         = cfg_ftw;
            start_phase_d = cfg_phase;
            len_d         = cfg_len;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = eff_phase[PHASE_W-1 -: ADDR_W];
                    phase_d    = eff_phase + eff_ftw;
                    cnt_d      = CNT_ONE;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (burst_end) begin
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = phase_q[PHASE_W-1 -: ADDR_W];
                    phase_d    = phase_q + ftw_q;
                    cnt_d      = cnt_q + CNT_ONE;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cfg_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // rom_en delayed by the ROM latency marks the cycles where rom_data is meaningful.
    generate
        for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_en_pipe
            if (gi == 0) begin : g_first
                assign en_pipe_d[gi] = rom_en_q;
            end else begin : g_rest
                assign en_pipe_d[gi] = en_pipe_q[gi-1];
            end
        end
    endgenerate

    assign data_present = en_pipe_q[ROM_LAT-1];

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = data_present;
        if (data_present) begin
            dout_d = rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            ftw_q         <= '0;
            start_phase_q <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            drain_cnt_q   <= '0;
            rom_en_q      <= 1'b0;
            rom_addr_q    <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_ready_q   <= 1'b1;
            en_pipe_q     <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            ftw_q         <= ftw_d;
            start_phase_q <= start_phase_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            rom_en_q      <= rom_en_d;
            rom_addr_q    <= rom_addr_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_ready_q   <= cfg_ready_d;
            en_pipe_q     <= en_pipe_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
